// File: rtl/select_arbiter.sv
// Round-robin arbiter: one of NREQ requesters is granted, its key is decoded and the result is registered.
// Latency 1: the result appears on out_valid the cycle after the grant; back-to-back results issue one per cycle.
// Backpressure: out_ready=0 holds the result and masks every req_ready bit; a result is replaced only as it is consumed.
// Optional build macro SELARB_MISS_CNT_EN adds an 8-bit saturating miss counter on port miss_cnt.
module select_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_key,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [1:0]        out_id,
  output logic              out_hit
`ifdef SELARB_MISS_CNT_EN
  ,
  output logic [7:0]        miss_cnt
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t         r_state;
  logic [1:0]     r_rr_ptr;
  logic           r_out_valid;
  logic [N-1:0]   r_out_data;
  logic [1:0]     r_out_id;
  logic           r_out_hit;

  int             w_scan;
  logic           w_found;
  logic [1:0]     w_gnt_idx;
  logic           w_window;
  logic           w_accept;
  logic [1:0]     w_ptr_nxt;
  logic [N-1:0]   w_key;
  logic [N-1:0]   w_b;
  logic [N-1:0]   w_c;
  logic [N-1:0]   w_res;
  logic           w_hit;

  // A new request may enter when nothing is held, or when the held result leaves this cycle.
  assign w_window = (r_state == ST_IDLE) || out_ready;
  assign w_accept = w_window && w_found;

  // Round-robin search: first valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_scan    = 0;
    w_found   = 1'b0;
    w_gnt_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NREQ) begin
        w_scan = w_scan - NREQ;
      end
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = 2'(w_scan);
      end
    end
  end

  // Grant is one-hot on the winner and only inside an acceptance window.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept && (w_gnt_idx == 2'(i));
    end
  end

  // Operands of the winning requester.
  assign w_key = req_key[int'(w_gnt_idx)*N +: N];
  assign w_b   = req_b[int'(w_gnt_idx)*N +: N];
  assign w_c   = req_c[int'(w_gnt_idx)*N +: N];

  // Key decode, first match wins; a miss yields zero data and no hit.
  always_comb begin
    w_res = '0;
    w_hit = 1'b1;
    if (w_key[N-1:1] == '0) begin
      w_res = w_b;
    end else if (w_key == N'(42)) begin
      w_res = w_c;
    end else if (w_key == N'(69)) begin
      w_res = w_b & w_c;
    end else begin
      w_res = '0;
      w_hit = 1'b0;
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  assign w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? 2'd0 : (w_gnt_idx + 2'd1);

  // Control FSM with registered result; reset drops any held result without a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 2'd0;
      r_out_hit   <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_RESP;
      r_rr_ptr    <= w_ptr_nxt;
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_id    <= w_gnt_idx;
      r_out_hit   <= w_hit;
    end else if ((r_state == ST_RESP) && out_ready) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_hit   = r_out_hit;

`ifdef SELARB_MISS_CNT_EN
  logic [7:0] r_miss_cnt;

  // Count accepted requests whose key missed, sticking at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_cnt <= 8'd0;
    end else if (w_accept && !w_hit && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_select_arbiter.sv
// Directed bench for select_arbiter (N=32, NREQ=3).
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Miss-counter checks are compiled only when SELARB_MISS_CNT_EN is defined.
module tb_select_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_key;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*N-1:0] req_c;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic [1:0]        out_id;
  logic              out_hit;
`ifdef SELARB_MISS_CNT_EN
  logic [7:0]        miss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  select_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_b     (req_b),
    .req_c     (req_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_hit   (out_hit)
`ifdef SELARB_MISS_CNT_EN
    ,
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [N-1:0] key, input logic [N-1:0] b, input logic [N-1:0] c);
    req_key[i*N +: N] = key;
    req_b[i*N +: N]   = b;
    req_c[i*N +: N]   = c;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
    n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d exp 0", out_id); end
    n_tests++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b exp 0", out_hit); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_rdy got %b exp 000", req_ready); end
`ifdef SELARB_MISS_CNT_EN
    n_tests++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_miss got %0d exp 0", miss_cnt); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    set_req(0, 32'd1, 32'hA5, 32'h0);
    req_valid = 3'b001;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_rdy got %b exp 001", req_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid got %b exp 0", out_valid); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_tests++; if (out_data !== 32'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", out_data); end
    n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d exp 0", out_id); end
    n_tests++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit got %b exp 1", out_hit); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL single_rdy_after got %b exp 000", req_ready); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin;
    do_reset();
    set_req(0, 32'd42, 32'h0,  32'd7);
    set_req(1, 32'd69, 32'hF0, 32'h3C);
    set_req(2, 32'd0,  32'd9,  32'h0);
    req_valid = 3'b111;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rr_rdy0 got %b exp 001", req_ready); end
    @(negedge clk);
    req_valid = 3'b110;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid0 got %b exp 1", out_valid); end
    n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL rr_id0 got %0d exp 0", out_id); end
    n_tests++; if (out_data !== 32'd7) begin n_fail++; $display("FAIL rr_data0 got %h exp 7", out_data); end
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rr_rdy1 got %b exp 010", req_ready); end
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    n_tests++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL rr_id1 got %0d exp 1", out_id); end
    n_tests++; if (out_data !== 32'h30) begin n_fail++; $display("FAIL rr_data1 got %h exp 30", out_data); end
    n_tests++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL rr_hit1 got %b exp 1", out_hit); end
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL rr_rdy2 got %b exp 100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL rr_id2 got %0d exp 2", out_id); end
    n_tests++; if (out_data !== 32'd9) begin n_fail++; $display("FAIL rr_data2 got %h exp 9", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid2 got %b exp 1", out_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    set_req(0, 32'd42, 32'h0, 32'h55);
    req_valid = 3'b001;
    out_ready = 1'b0;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL bp_idle_rdy got %b exp 001", req_ready); end
    @(negedge clk);
    set_req(1, 32'd1, 32'h11, 32'h0);
    req_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, out_valid); end
      n_tests++; if (out_data !== 32'h55) begin n_fail++; $display("FAIL bp_data cyc %0d got %h exp 55", c, out_data); end
      n_tests++; if (out_id !== 2'd0 || out_hit !== 1'b1) begin n_fail++; $display("FAIL bp_id_hit cyc %0d got %0d/%b exp 0/1", c, out_id, out_hit); end
      n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_rdy cyc %0d got %b exp 000", c, req_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 010", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL bp_next_id got %0d exp 1", out_id); end
    n_tests++; if (out_data !== 32'h11) begin n_fail++; $display("FAIL bp_next_data got %h exp 11", out_data); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_miss;
    @(negedge clk);
    set_req(0, 32'd2, 32'hFF, 32'hEE);
    req_valid = 3'b001;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL miss_rdy0 got %b exp 001", req_ready); end
    @(negedge clk);
    set_req(0, 32'd43, 32'hFF, 32'hEE);
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid0 got %b exp 1", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL miss_data0 got %h exp 0", out_data); end
    n_tests++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit0 got %b exp 0", out_hit); end
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL miss_rdy1 got %b exp 001", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid1 got %b exp 1", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL miss_data1 got %h exp 0", out_data); end
    n_tests++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit1 got %b exp 0", out_hit); end
`ifdef SELARB_MISS_CNT_EN
    n_tests++; if (miss_cnt !== 8'd2) begin n_fail++; $display("FAIL miss_cnt2 got %0d exp 2", miss_cnt); end
    @(negedge clk);
    req_valid = 3'b001;
    repeat (298) @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (miss_cnt !== 8'd255) begin n_fail++; $display("FAIL miss_cnt_sat got %0d exp 255", miss_cnt); end
`endif
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL miss_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_resp;
    @(negedge clk);
    set_req(0, 32'd1, 32'd3, 32'h0);
    req_valid = 3'b001;
    out_ready = 1'b0;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rmr_rdy got %b exp 001", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin n_fail++; $display("FAIL rmr_held got %b/%h exp 1/3", out_valid, out_data); end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_async_valid got %b exp 0", out_valid); end
    n_tests++; if (out_data !== 32'h0 || out_hit !== 1'b0 || out_id !== 2'd0) begin n_fail++; $display("FAIL rmr_async_out got %h/%b/%0d exp 0/0/0", out_data, out_hit, out_id); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 32'd1,  32'h11, 32'h0);
    set_req(2, 32'd42, 32'h0,  32'h22);
    req_valid = 3'b110;
    out_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rmr_first_rdy got %b exp 010", req_ready); end
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    n_tests++; if (out_id !== 2'd1 || out_data !== 32'h11) begin n_fail++; $display("FAIL rmr_first_out got %0d/%h exp 1/11", out_id, out_data); end
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL rmr_second_rdy got %b exp 100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    n_tests++; if (out_id !== 2'd2 || out_data !== 32'h22) begin n_fail++; $display("FAIL rmr_second_out got %0d/%h exp 2/22", out_id, out_data); end
    @(negedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_key   = '0;
    req_b     = '0;
    req_c     = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_miss();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
